// File: rtl/branch_pkg.sv
// Shared encodings for the branch/PC unit: FSM states, branch funct3 codes
// and the default reset PC.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode from funct3 and comparator flags.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       cond
);

  // BrLT is only trusted when the operands differ, hence the !BrEq terms.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      BEQ:        cond = BrEq;
      BNE:        cond = !BrEq;
      BLT, BLTU:  cond = !BrEq && BrLT;
      BGE, BGEU:  cond = BrEq || !BrLT;
      default:    cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter with branch/jump redirect, one-cycle flush, misalignment
// trap and branch statistics counters.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int          n        = 32,
  parameter logic [n-1:0] RESET_PC = n'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         Branch,
  input  logic         Jump,
  input  logic [2:0]   funct3,
  input  logic         BrEq,
  input  logic         BrLT,
  input  logic [n-1:0] Target,
  output logic         BrUn,
  output logic [n-1:0] PC,
  output logic [n-1:0] PC4,
  output logic         Flush,
  output logic         Misalign,
  output logic [31:0]  BrCount,
  output logic [31:0]  TakenCount,
  output logic [1:0]   fsm_state
);

  state_t        state;
  logic [n-1:0]  pc;
  logic          flush;
  logic          misalign;
  logic [31:0]   br_count;
  logic [31:0]   taken_count;
  logic          cond;
  logic          taken;
  logic          count_branch;

  branch_cond u_cond (
    .funct3 (funct3),
    .BrEq   (BrEq),
    .BrLT   (BrLT),
    .cond   (cond)
  );

  assign taken        = Jump || (Branch && cond);
  // Jumps win over Branch and are never counted as conditional branches.
  assign count_branch = Branch && !Jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      br_count    <= 32'd0;
      taken_count <= 32'd0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (count_branch) begin
            br_count <= br_count + 32'd1;
            if (cond) taken_count <= taken_count + 32'd1;
          end
          if (!taken) begin
            pc <= pc + n'(4);
          end else if (Target[1:0] == 2'b00) begin
            pc    <= Target;
            state <= ST_FLUSH;
            flush <= 1'b1;
          end else begin
            misalign <= 1'b1;
            state    <= ST_TRAP;
          end
        end
        ST_FLUSH: begin
          pc    <= pc + n'(4);
          state <= ST_RUN;
          flush <= 1'b0;
        end
        default: begin
          state <= ST_TRAP;
        end
      endcase
    end
  end

  assign BrUn       = funct3[1];
  assign PC         = pc;
  assign PC4        = pc + n'(4);
  assign Flush      = flush;
  assign Misalign   = misalign;
  assign BrCount    = br_count;
  assign TakenCount = taken_count;
  assign fsm_state  = state;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed table-driven bench for branch_pc_unit plus hand sequences for
// trap, stall-in-flush, reset-in-flush and wrap-around corners.
module tb_branch_pc_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        br_eq = 1'b0;
  logic        br_lt = 1'b0;
  logic [31:0] target = 32'd0;
  logic        br_un;
  logic [31:0] pc, pc4;
  logic        flush, misalign;
  logic [31:0] br_count, taken_count;
  logic [1:0]  fsm_state;

  logic        w_rst = 1'b1;
  logic        w_br_un, w_flush, w_misalign;
  logic [31:0] w_pc, w_pc4, w_br_count, w_taken_count;
  logic [1:0]  w_fsm_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.n(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .Branch(branch), .Jump(jump),
    .funct3(funct3), .BrEq(br_eq), .BrLT(br_lt), .Target(target),
    .BrUn(br_un), .PC(pc), .PC4(pc4), .Flush(flush), .Misalign(misalign),
    .BrCount(br_count), .TakenCount(taken_count), .fsm_state(fsm_state)
  );

  branch_pc_unit #(.n(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst), .stall(1'b0), .Branch(1'b0), .Jump(1'b0),
    .funct3(3'b000), .BrEq(1'b0), .BrLT(1'b0), .Target(32'h0),
    .BrUn(w_br_un), .PC(w_pc), .PC4(w_pc4), .Flush(w_flush), .Misalign(w_misalign),
    .BrCount(w_br_count), .TakenCount(w_taken_count), .fsm_state(w_fsm_state)
  );

  typedef struct {
    logic        s, b, j;
    logic [2:0]  f3;
    logic        eq, lt;
    logic [31:0] tg;
    logic [31:0] pc;
    logic        fl;
    logic [1:0]  st;
    logic [31:0] br, tk;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic b, logic j, logic [2:0] f3,
                              logic eq, logic lt, logic [31:0] tg,
                              logic [31:0] epc, logic fl, logic [1:0] st,
                              logic [31:0] br, logic [31:0] tk, logic mis);
    vec_t v;
    v.s = s; v.b = b; v.j = j; v.f3 = f3; v.eq = eq; v.lt = lt; v.tg = tg;
    v.pc = epc; v.fl = fl; v.st = st; v.br = br; v.tk = tk; v.mis = mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic j, input logic [2:0] f3,
                       input logic eq, input logic lt, input logic [31:0] tg);
    stall = s; branch = b; jump = j; funct3 = f3; br_eq = eq; br_lt = lt; target = tg;
  endtask

  task automatic check_state(input string tag, input logic [31:0] epc, input logic fl,
                             input logic [1:0] st, input logic [31:0] br,
                             input logic [31:0] tk, input logic mis);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".pc4"}, pc4, epc + 32'd4);
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
    check({tag, ".state"}, {30'd0, fsm_state}, {30'd0, st});
    check({tag, ".brcount"}, br_count, br);
    check({tag, ".takencount"}, taken_count, tk);
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, mis});
  endtask

  initial begin
    // Sequence starts from PC=0 after reset; each row is one clock edge.
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'h4,  0,ST_RUN,  0,0,0));
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'h8,  0,ST_RUN,  0,0,0));
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'hC,  0,ST_RUN,  0,0,0));
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'h10, 0,ST_RUN,  0,0,0));
    vecs.push_back(mk(0,1,0,BEQ,1,0,32'h40,  32'h40, 1,ST_FLUSH,1,1,0));
    vecs.push_back(mk(0,1,1,BEQ,1,0,32'h80,  32'h44, 0,ST_RUN,  1,1,0));
    vecs.push_back(mk(0,1,0,BGE,0,1,32'h100, 32'h48, 0,ST_RUN,  2,1,0));
    vecs.push_back(mk(0,1,0,BNE,0,0,32'h200, 32'h200,1,ST_FLUSH,3,2,0));
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'h204,0,ST_RUN,  3,2,0));
    vecs.push_back(mk(0,1,0,BLTU,0,1,32'h300,32'h300,1,ST_FLUSH,4,3,0));
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'h304,0,ST_RUN,  4,3,0));
    vecs.push_back(mk(0,1,0,3'b010,1,0,32'h900,32'h308,0,ST_RUN,5,3,0));
    vecs.push_back(mk(0,1,0,BLT,1,1,32'h500, 32'h30C,0,ST_RUN,  6,3,0));
    vecs.push_back(mk(0,1,0,BGEU,1,1,32'h400,32'h400,1,ST_FLUSH,7,4,0));
    vecs.push_back(mk(1,0,0,BEQ,0,0,32'h0,   32'h400,1,ST_FLUSH,7,4,0));
    vecs.push_back(mk(1,1,0,BEQ,1,0,32'h800, 32'h400,1,ST_FLUSH,7,4,0));
    vecs.push_back(mk(1,0,1,BEQ,0,0,32'h800, 32'h400,1,ST_FLUSH,7,4,0));
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'h404,0,ST_RUN,  7,4,0));
    vecs.push_back(mk(1,1,0,BEQ,1,0,32'h500, 32'h404,0,ST_RUN,  7,4,0));
    vecs.push_back(mk(0,0,1,BEQ,0,0,32'h600, 32'h600,1,ST_FLUSH,7,4,0));
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'h604,0,ST_RUN,  7,4,0));
    vecs.push_back(mk(0,1,1,BEQ,0,0,32'h700, 32'h700,1,ST_FLUSH,7,4,0));
    vecs.push_back(mk(0,0,0,BEQ,0,0,32'h0,   32'h704,0,ST_RUN,  7,4,0));
    vecs.push_back(mk(0,1,0,BEQ,1,0,32'h702, 32'h704,0,ST_TRAP, 8,5,1));
    vecs.push_back(mk(0,1,0,BEQ,1,0,32'h800, 32'h704,0,ST_TRAP, 8,5,1));
    vecs.push_back(mk(0,0,1,BEQ,0,0,32'h900, 32'h704,0,ST_TRAP, 8,5,1));

    // Reset held for two edges.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_state("reset", 32'h0, 0, ST_RUN, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s, vecs[i].b, vecs[i].j, vecs[i].f3, vecs[i].eq, vecs[i].lt, vecs[i].tg);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fl, vecs[i].st,
                  vecs[i].br, vecs[i].tk, vecs[i].mis);
    end

    // Reset overrides stall and TRAP.
    drive(1,1,1,BEQ,1,0,32'h40);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state("rst_trap", 32'h0, 0, ST_RUN, 0, 0, 0);

    // BrUn follows funct3[1].
    drive(0,0,0,BLTU,0,0,32'h0);
    #1 check("brun_110", {31'd0, br_un}, 32'd1);
    drive(0,0,0,BGE,0,0,32'h0);
    #1 check("brun_101", {31'd0, br_un}, 32'd0);

    // Misaligned jump: trap and freeze, then reset recovers.
    drive(0,0,0,BEQ,0,0,32'h0);
    step();
    drive(0,0,1,BEQ,0,0,32'h102);
    step();
    check_state("jmp_mis", 32'h4, 0, ST_TRAP, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'(i % 2), 1'(i % 3 == 0), BEQ, 1, 0, 32'h200 + 32'(i * 16));
      step();
      check_state($sformatf("trap_hold%0d", i), 32'h4, 0, ST_TRAP, 0, 0, 1);
    end
    drive(0,0,0,BEQ,0,0,32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state("trap_rst", 32'h0, 0, ST_RUN, 0, 0, 0);

    // Reset in FLUSH with stall asserted leaves no residual Flush.
    drive(0,1,0,BEQ,1,0,32'h40);
    step();
    check_state("pre_rst_flush", 32'h40, 1, ST_FLUSH, 1, 1, 0);
    drive(1,0,0,BEQ,0,0,32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state("rst_flush", 32'h0, 0, ST_RUN, 0, 0, 0);
    drive(0,0,0,BEQ,0,0,32'h0);
    step();
    check_state("post_rst_flush", 32'h4, 0, ST_RUN, 0, 0, 0);

    // Counter wrap from all-ones.
    force dut.br_count = 32'hFFFF_FFFF;
    force dut.taken_count = 32'hFFFF_FFFF;
    #1;
    release dut.br_count;
    release dut.taken_count;
    drive(0,1,0,BEQ,1,0,32'h80);
    step();
    check_state("cnt_wrap", 32'h80, 1, ST_FLUSH, 0, 0, 0);
    drive(0,0,0,BEQ,0,0,32'h0);
    step();

    // PC wraps modulo 2^32 on the second instance.
    w_rst = 1'b1;
    step();
    check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", w_pc4, 32'h0);
    w_rst = 1'b0;
    step();
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_flush", {31'd0, w_flush}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
